// File: rtl/fifo_sync_status_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_sync_status.
// The master side drives requests and write data; the slave side (the FIFO)
// drives the show-ahead head entry, occupancy and status flags.
interface fifo_sync_status_if #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  wren;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  rden;
   logic                  flush;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wren, i_data, rden, flush, clr_err,
      input  o_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wren, i_data, rden, flush, clr_err,
      output o_data, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_status.sv
// Single-clock show-ahead FIFO with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags. Status flags are registered from the
// next-state count so no request input reaches them combinationally.
module fifo_sync_status #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_sync_status_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Pointer advance with explicit wrap so non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == LAST_PTR) begin
         n = {PW{1'b0}};
      end else begin
         n = p + PW'(1);
      end
      return n;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          full_q,   full_d;
   logic          empty_q,  empty_d;
   logic          af_q,     af_d;
   logic          ae_q,     ae_d;
   logic          ovf_q,    ovf_d;
   logic          udf_q,    udf_d;

   logic rd_ok_s;
   logic wr_ok_s;
   logic wr_en_s;
   logic ovf_set_s;
   logic udf_set_s;

   // A write while full is only accepted when the head pops in the same cycle.
   assign rd_ok_s   = bus.rden & ~empty_q;
   assign wr_ok_s   = bus.wren & (~full_q | bus.rden);
   assign wr_en_s   = wr_ok_s & ~bus.flush;
   assign ovf_set_s = bus.wren & full_q & ~bus.rden & ~bus.flush;
   assign udf_set_s = bus.rden & empty_q & ~bus.flush;

   // Next-state pointers, occupancy, derived flags and sticky error flags.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (wr_ok_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      full_d  = (count_d == DEPTH_C);
      empty_d = (count_d == {CW{1'b0}});
      af_d    = (count_d >= AF_C);
      ae_d    = (count_d <= AE_C);

      // A new error event wins over a simultaneous clear.
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (bus.clr_err) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (udf_set_s) begin
         udf_d = 1'b1;
      end else if (bus.clr_err) begin
         udf_d = 1'b0;
      end else begin
         udf_d = udf_q;
      end
   end

   // Control and status state; asynchronous return to the empty state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage array; intentionally not reset, written only on an accepted write.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= bus.i_data;
      end
   end

   // Show-ahead head entry, forced to zero while empty so stale data never leaks.
   assign bus.o_data       = empty_q ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_status.sv
// Bench for fifo_sync_status: a DEPTH=8 and a DEPTH=5 instance receive the same
// directed stimulus. A shift-array occupancy model per instance is checked
// against both DUTs on every falling edge, and literal expectations pin the
// model on the key scenarios.
module tb_fifo_sync_status;
   logic       clk;
   logic       rst_n;
   logic       wren;
   logic [7:0] i_data;
   logic       rden;
   logic       flush;
   logic       clr_err;

   int n_vec = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   fifo_sync_status_if #(.DEPTH(8), .DATA_WIDTH(8)) if8 ();
   fifo_sync_status_if #(.DEPTH(5), .DATA_WIDTH(8)) if5 ();

   assign if8.wren = wren;  assign if8.i_data = i_data; assign if8.rden = rden;
   assign if8.flush = flush; assign if8.clr_err = clr_err;
   assign if5.wren = wren;  assign if5.i_data = i_data; assign if5.rden = rden;
   assign if5.flush = flush; assign if5.clr_err = clr_err;

   fifo_sync_status #(.DEPTH(8), .DATA_WIDTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(if8.slave));
   fifo_sync_status #(.DEPTH(5), .DATA_WIDTH(8), .AF_THRESH(4), .AE_THRESH(1)) dut5 (
      .clk(clk), .rst_n(rst_n), .bus(if5.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0] mdat [2][8];
   int         msz  [2];
   logic       movf [2];
   logic       mudf [2];
   logic [7:0] t_dat [8];
   int         t_sz;
   int         t_d;
   bit         t_pop;
   bit         t_push;

   // Model update: queue semantics in a shifting array, head at index 0.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin
            msz[m]  <= 0;
            movf[m] <= 1'b0;
            mudf[m] <= 1'b0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            t_d = (m == 0) ? 8 : 5;
            for (int k = 0; k < 8; k++) t_dat[k] = mdat[m][k];
            t_sz = msz[m];
            if (flush) begin
               t_sz = 0;
            end else begin
               t_pop  = rden && (t_sz > 0);
               t_push = wren && ((t_sz < t_d) || rden);
               if (t_pop) begin
                  for (int k = 0; k < 7; k++) t_dat[k] = t_dat[k+1];
                  t_sz = t_sz - 1;
               end
               if (t_push) begin
                  t_dat[t_sz] = i_data;
                  t_sz = t_sz + 1;
               end
            end
            if (!flush && wren && !rden && msz[m] == t_d) movf[m] <= 1'b1;
            else if (clr_err) movf[m] <= 1'b0;
            if (!flush && rden && msz[m] == 0) mudf[m] <= 1'b1;
            else if (clr_err) mudf[m] <= 1'b0;
            for (int k = 0; k < 8; k++) mdat[m][k] <= t_dat[k];
            msz[m] <= t_sz;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_one(input int m, input logic [7:0] od, input logic f, input logic e,
                          input logic af, input logic ae, input logic [31:0] cnt,
                          input logic ov, input logic un);
      int d, aft, aet, sz;
      d   = (m == 0) ? 8 : 5;
      aft = (m == 0) ? 6 : 4;
      aet = 1;
      sz  = msz[m];
      chk($sformatf("d%0d.count", d), cnt, 32'(sz));
      chk($sformatf("d%0d.full", d), {31'd0, f}, {31'd0, sz == d});
      chk($sformatf("d%0d.empty", d), {31'd0, e}, {31'd0, sz == 0});
      chk($sformatf("d%0d.almost_full", d), {31'd0, af}, {31'd0, sz >= aft});
      chk($sformatf("d%0d.almost_empty", d), {31'd0, ae}, {31'd0, sz <= aet});
      chk($sformatf("d%0d.o_data", d), {24'd0, od}, {24'd0, (sz > 0) ? mdat[m][0] : 8'h00});
      chk($sformatf("d%0d.overflow", d), {31'd0, ov}, {31'd0, movf[m]});
      chk($sformatf("d%0d.underflow", d), {31'd0, un}, {31'd0, mudf[m]});
   endtask

   // Compare process: both DUTs against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_one(0, if8.o_data, if8.full, if8.empty, if8.almost_full, if8.almost_empty,
                 32'(if8.count), if8.overflow, if8.underflow);
         cmp_one(1, if5.o_data, if5.full, if5.empty, if5.almost_full, if5.almost_empty,
                 32'(if5.count), if5.overflow, if5.underflow);
      end
   end

   // One clock of stimulus; returns 1 time unit after the consuming edge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
      wren = w; i_data = d; rden = r; flush = f; clr_err = c;
      @(posedge clk); #1;
      wren = 1'b0; rden = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wren = 1'b0; i_data = 8'h00; rden = 1'b0; flush = 1'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("reset.count", 32'(if8.count), 32'd0);
      chk("reset.empty", {31'd0, if8.empty}, 32'd1);
      chk("reset.almost_empty", {31'd0, if8.almost_empty}, 32'd1);
      chk("reset.almost_full", {31'd0, if8.almost_full}, 32'd0);
      chk("reset.o_data", {24'd0, if8.o_data}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: fill DEPTH=8 with 0x10..0x17, then drain in order
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
         chk("s1.count", 32'(if8.count), 32'(i + 1));
         chk("s1.almost_full", {31'd0, if8.almost_full}, {31'd0, (i + 1) >= 6});
         chk("s1.full", {31'd0, if8.full}, {31'd0, (i + 1) == 8});
      end
      for (int i = 0; i < 8; i++) begin
         chk("s1.head", {24'd0, if8.o_data}, 32'(8'h10 + i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         chk("s1.count_rd", 32'(if8.count), 32'(7 - i));
         chk("s1.almost_empty", {31'd0, if8.almost_empty}, {31'd0, (7 - i) <= 1});
         chk("s1.empty", {31'd0, if8.empty}, {31'd0, i == 7});
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // 2: three fill/drain rounds on DEPTH=5 exercise the 4->0 pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h20 + r * 5 + i), 1'b0, 1'b0, 1'b0);
            chk("s2.count", 32'(if5.count), 32'(i + 1));
         end
         chk("s2.full", {31'd0, if5.full}, 32'd1);
         for (int i = 0; i < 5; i++) begin
            chk("s2.head", {24'd0, if5.o_data}, 32'(8'h20 + r * 5 + i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("s2.count_rd", 32'(if5.count), 32'(4 - i));
         end
      end

      // 3: full + simultaneous write/read, then dropped write while full
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      chk("s3.count_rw", 32'(if8.count), 32'd8);
      chk("s3.head_rw", {24'd0, if8.o_data}, 32'h31);
      cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
      chk("s3.count_drop", 32'(if8.count), 32'd8);
      chk("s3.overflow", {31'd0, if8.overflow}, 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("s3.overflow_hold", {31'd0, if8.overflow}, 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("s3.overflow_clr", {31'd0, if8.overflow}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("s3.drain", {24'd0, if8.o_data}, (i < 7) ? 32'(8'h31 + i) : 32'hAA);
         cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // 4: underflow, no fall-through, clear vs. new event
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s4.underflow", {31'd0, if8.underflow}, 32'd1);
      chk("s4.count0", 32'(if8.count), 32'd0);
      chk("s4.o_data0", {24'd0, if8.o_data}, 32'd0);
      cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      chk("s4.count1", 32'(if8.count), 32'd1);
      chk("s4.o_data55", {24'd0, if8.o_data}, 32'h55);
      chk("s4.underflow_set", {31'd0, if8.underflow}, 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk("s4.set_wins", {31'd0, if8.underflow}, 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("s4.underflow_clr", {31'd0, if8.underflow}, 32'd0);

      // 5: flush at count 4 overrides a write and leaves error flags alone
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      chk("s5.count4", 32'(if8.count), 32'd4);
      cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      chk("s5.count", 32'(if8.count), 32'd0);
      chk("s5.empty", {31'd0, if8.empty}, 32'd1);
      chk("s5.o_data", {24'd0, if8.o_data}, 32'd0);
      chk("s5.underflow_kept", {31'd0, if8.underflow}, 32'd1);
      chk("s5.overflow_kept", {31'd0, if8.overflow}, 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // 6: asynchronous reset mid-burst at count 5
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      chk("s6.count5", 32'(if8.count), 32'd5);
      wren = 1'b1; i_data = 8'h65;
      #2 rst_n = 1'b0;
      #1;
      chk("s6.rst_count", 32'(if8.count), 32'd0);
      chk("s6.rst_empty", {31'd0, if8.empty}, 32'd1);
      chk("s6.rst_o_data", {24'd0, if8.o_data}, 32'd0);
      chk("s6.rst_ae", {31'd0, if8.almost_empty}, 32'd1);
      chk("s6.rst_count5", 32'(if5.count), 32'd0);
      wren = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("s6.post_count", 32'(if8.count), 32'd1);
      chk("s6.post_o_data", {24'd0, if8.o_data}, 32'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("s6.post_empty", {31'd0, if8.empty}, 32'd1);

      @(posedge clk); #1;
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
